polinomio_horner_param: RTL and testbench
=========================================

Name: polinomio_horner_param

Overview:
- Parametrised multi-cycle polynomial evaluator: Resultado = a_GRAU*X^GRAU + ... + a_1*X + a_0, computed with Horner's rule.
- Uses one shared W x W multiplier and one adder under an internal FSM; control and datapath live in one block.
- Next generation of the fixed 16-bit, second-degree evaluator: width and degree are parameters, and it adds a busy flag, sticky signed overflow and defined restart rules.
- Same inicio/pronto handshake as the existing evaluator, so it drops into the same top-level sockets.

Parameters:
- W, 16, datapath width in bits; all operands and the result are signed two's complement.
- GRAU, 3, polynomial degree; legal range is GRAU >= 1.

Ports:
- ck  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- inicio  in  1  start request; sampled only in OCIOSO.
- X  in  W  evaluation point; captured at start.
- COEF  in  (GRAU+1)*W  coefficient bus; a_k = COEF[k*W +: W], a_0 is the constant term; captured at start.
- Resultado  out  W  registered result; valid while pronto=1.
- pronto  out  1  result valid; level signal.
- overflow  out  1  sticky signed-overflow flag for the last operation.
- ocupado  out  1  high while computing (states MULT and SOMA).

Behaviour:
- Reset (async, rst=0): state=OCIOSO; Resultado=0, pronto=0, overflow=0, ocupado=0; internal acc, prod, cnt, and captured X/COEF all cleared.
- Reset mid-operation aborts immediately; no partial result is ever presented.
- States: OCIOSO, MULT, SOMA, FIM.
- OCIOSO or FIM with inicio=1 at edge e0:
  - capture X and COEF;
  - acc <- a_GRAU, cnt <- GRAU;
  - overflow <- 0, pronto <- 0;
  - next state MULT.
- OCIOSO/FIM with inicio=0: hold; pronto, Resultado and overflow are unchanged.
- MULT, one edge:
  - prod <- acc * X_captured (full 2W signed product);
  - if prod[2W-1:W-1] is not all-equal, overflow <- 1;
  - next state SOMA.
- SOMA, one edge:
  - acc <- prod[W-1:0] + a_(cnt-1), wrapping modulo 2^W;
  - if the operand signs are equal and the sum sign differs, overflow <- 1;
  - cnt <- cnt-1;
  - if the new cnt = 0: Resultado <- new acc, pronto <- 1, next state FIM; else next state MULT.
- Latency: pronto rises after edge e0 + 2*GRAU (6 edges for GRAU=3). Throughput is one evaluation per 2*GRAU+1 cycles when restarted from FIM.
- inicio during MULT/SOMA is ignored: no restart and no queuing.
- overflow is sticky across all steps of one evaluation; it is cleared only by a new start or by reset.
- Resultado holds its value through FIM and any following OCIOSO time until the next evaluation completes.
- ocupado = 1 exactly in MULT/SOMA; pronto and ocupado are never both 1.
- cnt width is clog2(GRAU+1). The multiplier is combinational in MULT; no pipelining of the product is required.

Test Plan:
- W=16, GRAU=3; a3=1, a2=2, a1=3, a0=4; X=2; inicio pulse -> pronto rises exactly 6 edges later; Resultado=26; overflow=0; ocupado high for 6 cycles.
- a3=0, a2=1, a1=0, a0=-5 (0xFFFB); X=-3 (0xFFFD) -> Resultado=4 (0x0004), overflow=0.
- a3=1, others 0; X=256 -> the 256*256 product overflows -> Resultado=0x0000, overflow=1, held in FIM.
- a3=0x7FFF, a2=1, a1=0, a0=0; X=1 -> the first SOMA gives 0x7FFF+1 (sum overflow) -> Resultado=0x8000, overflow=1. Then restart from FIM with case 1 operands -> overflow clears at the start edge and Resultado=26.
- Hold inicio=1 continuously through a run -> no restart while ocupado=1. At FIM, the still-high inicio restarts on the next edge, dropping pronto; a result appears every 7 cycles.
- Assert rst=0 asynchronously 3 edges into a run -> all outputs read 0 immediately. Release and start case 2 -> Resultado=4 after 6 edges, with no stale overflow.

Source files
------------

// File: rtl/polinomio_horner_param.sv
// polinomio_horner_param: multi-cycle Horner polynomial evaluator with one shared multiplier and adder.
module polinomio_horner_param #(
    parameter int W    = 16,
    parameter int GRAU = 3
) (
    input  logic                    ck,
    input  logic                    rst,
    input  logic                    inicio,
    input  logic [W-1:0]            X,
    input  logic [(GRAU+1)*W-1:0]   COEF,
    output logic [W-1:0]            Resultado,
    output logic                    pronto,
    output logic                    overflow,
    output logic                    ocupado
);
    localparam int CW = (GRAU + 1 > 1) ? $clog2(GRAU + 1) : 1;

    typedef enum logic [1:0] {OCIOSO, MULT, SOMA, FIM} estado_t;

    estado_t                  estado, prox;
    logic signed [W-1:0]      acc, xc;
    logic signed [2*W-1:0]    mul;
    logic [W-1:0]             prod, ak, soma;
    logic [CW-1:0]            cnt;
    logic [(GRAU+1)*W-1:0]    coefc;
    logic [W-1:0]             a [GRAU+1];
    logic                     ov_mul, ov_soma;

    for (genvar k = 0; k <= GRAU; k++) begin : g_coef
        assign a[k] = coefc[k*W +: W];
    end

    // only the low half of the product feeds the adder; the high half is consumed by the overflow test
    assign mul      = acc * xc;
    assign ov_mul   = !(&mul[2*W-1:W-1] || ~|mul[2*W-1:W-1]);
    assign ak       = a[cnt - 1'b1];
    assign soma     = prod + ak;
    assign ov_soma  = (prod[W-1] == ak[W-1]) && (soma[W-1] != ak[W-1]);
    assign ocupado  = (estado == MULT) || (estado == SOMA);

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) estado <= OCIOSO;
        else      estado <= prox;
    end

    always_comb begin
        prox = estado;
        unique case (estado)
            OCIOSO, FIM: prox = inicio ? MULT : estado;
            MULT:        prox = SOMA;
            SOMA:        prox = (cnt == CW'(1)) ? FIM : MULT;
            default:     prox = OCIOSO;
        endcase
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            xc        <= '0;
            prod      <= '0;
            cnt       <= '0;
            coefc     <= '0;
            Resultado <= '0;
            pronto    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (estado)
                OCIOSO, FIM: if (inicio) begin
                    xc       <= X;
                    coefc    <= COEF;
                    acc      <= COEF[GRAU*W +: W];
                    cnt      <= CW'(GRAU);
                    overflow <= 1'b0;
                    pronto   <= 1'b0;
                end
                MULT: begin
                    prod <= mul[W-1:0];
                    if (ov_mul) overflow <= 1'b1;
                end
                SOMA: begin
                    acc <= soma;
                    cnt <= cnt - 1'b1;
                    if (ov_soma) overflow <= 1'b1;
                    if (cnt == CW'(1)) begin
                        Resultado <= soma;
                        pronto    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_polinomio_horner_param.sv
// tb_polinomio_horner_param: random and directed checks of the Horner evaluator against a range-based arithmetic model.
module tb_polinomio_horner_param;
    localparam int W    = 16;
    localparam int GRAU = 3;
    localparam int CB   = (GRAU+1)*W;

    logic          ck = 1'b0, rst = 1'b0, inicio = 1'b0;
    logic [W-1:0]  X = '0;
    logic [CB-1:0] COEF = '0;
    logic [W-1:0]  Resultado;
    logic          pronto, overflow, ocupado;

    int checks = 0, failures = 0;

    polinomio_horner_param #(.W(W), .GRAU(GRAU)) dut (
        .ck(ck), .rst(rst), .inicio(inicio), .X(X), .COEF(COEF),
        .Resultado(Resultado), .pronto(pronto), .overflow(overflow), .ocupado(ocupado)
    );

    always #5 ck = ~ck;

    task automatic chk(input string nome, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", nome, got, want, $time);
        end
    endtask

    function automatic longint wrap(input longint v);
        longint m;
        m = v & ((64'd1 << W) - 1);
        return (m >= (64'd1 << (W-1))) ? m - (64'd1 << W) : m;
    endfunction

    // returns {overflow, result}; overflow means any intermediate value left the signed W-bit range
    function automatic logic [W:0] horner(input logic [W-1:0] x, input logic [CB-1:0] c);
        longint acc, p, s, lo, hi, xs;
        logic ov;
        lo  = -(64'sd1 <<< (W-1));
        hi  = (64'sd1 <<< (W-1)) - 1;
        xs  = longint'($signed(x));
        acc = longint'($signed(c[GRAU*W +: W]));
        ov  = 1'b0;
        for (int k = GRAU-1; k >= 0; k--) begin
            p = acc * xs;
            if (p < lo || p > hi) ov = 1'b1;
            s = wrap(p) + longint'($signed(c[k*W +: W]));
            if (s < lo || s > hi) ov = 1'b1;
            acc = wrap(s);
        end
        return {ov, acc[W-1:0]};
    endfunction

    function automatic logic [CB-1:0] pack(input int a3, input int a2, input int a1, input int a0);
        logic [W-1:0] b3, b2, b1, b0;
        b3 = a3[W-1:0]; b2 = a2[W-1:0]; b1 = a1[W-1:0]; b0 = a0[W-1:0];
        return {b3, b2, b1, b0};
    endfunction

    int           m_busy = 0;
    logic         m_done = 1'b0, m_ov = 1'b0;
    logic [W-1:0] m_res = '0, m_nres = '0;
    logic         m_nov = 1'b0;

    always @(posedge ck or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_done <= 1'b0; m_ov <= 1'b0; m_res <= '0;
        end else if (m_busy == 0 && inicio) begin
            {m_nov, m_nres} <= horner(X, COEF);
            m_busy <= 2*GRAU; m_done <= 1'b0; m_ov <= 1'b0;
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                m_done <= 1'b1; m_res <= m_nres; m_ov <= m_nov;
            end
        end
    end

    always @(negedge ck) begin
        if (rst) begin
            chk("ocupado", ocupado, m_busy > 0);
            chk("pronto", pronto, m_done);
            if (m_busy == 0) begin
                chk("Resultado", Resultado, m_res);
                chk("overflow", overflow, m_ov);
            end
        end
    end

    task automatic run(input string nome, input logic [W-1:0] x, input logic [CB-1:0] c,
                       input logic [W-1:0] res, input logic ov);
        int n, occ;
        @(negedge ck);
        X = x; COEF = c; inicio = 1'b1;
        @(posedge ck); #1;
        inicio = 1'b0;
        chk({nome, "_start_pronto"}, pronto, 0);
        chk({nome, "_start_ov"}, overflow, 0);
        n = 0; occ = ocupado;
        while (!pronto && n < 20) begin
            @(posedge ck); #1;
            n++;
            occ += ocupado;
        end
        chk({nome, "_latency"}, n, 2*GRAU);
        chk({nome, "_ocupado_cycles"}, occ, 2*GRAU);
        chk({nome, "_res"}, Resultado, res);
        chk({nome, "_ov"}, overflow, ov);
        repeat (3) @(posedge ck);
        #1 chk({nome, "_hold_res"}, Resultado, res);
        chk({nome, "_hold_ov"}, overflow, ov);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [CB-1:0] c1, c2, c3, c4;
        logic [W:0]    h;
        int            t[$];
        int            cyc;
        logic          prev;
        c1 = pack(1, 2, 3, 4);
        c2 = pack(0, 1, 0, -5);
        c3 = pack(1, 0, 0, 0);
        c4 = pack(32'h7FFF, 1, 0, 0);

        h = horner(16'd2, c1);       chk("model_c1", h, {1'b0, 16'd26});
        h = horner(16'hFFFD, c2);    chk("model_c2", h, {1'b0, 16'd4});
        h = horner(16'd256, c3);     chk("model_c3", h, {1'b1, 16'h0000});
        h = horner(16'd1, c4);       chk("model_c4", h, {1'b1, 16'h8000});

        #12;
        chk("rst_res", Resultado, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_ov", overflow, 0);
        chk("rst_ocupado", ocupado, 0);
        @(negedge ck); rst = 1'b1;

        run("c1", 16'd2, c1, 16'd26, 1'b0);
        run("c2", 16'hFFFD, c2, 16'd4, 1'b0);
        run("c3", 16'd256, c3, 16'h0000, 1'b1);
        run("c4", 16'd1, c4, 16'h8000, 1'b1);
        run("c4_restart", 16'd2, c1, 16'd26, 1'b0);

        @(negedge ck);
        X = 16'd2; COEF = c1; inicio = 1'b1;
        cyc = 0; prev = pronto;
        repeat (30) begin
            @(posedge ck); #1;
            cyc++;
            if (pronto && !prev) t.push_back(cyc);
            if (ocupado && pronto) chk("excl", 1, 0);
            prev = pronto;
        end
        inicio = 1'b0;
        chk("hold_results", t.size() >= 3, 1);
        if (t.size() >= 3) begin
            chk("hold_period1", t[1] - t[0], 2*GRAU + 1);
            chk("hold_period2", t[2] - t[1], 2*GRAU + 1);
        end
        while (ocupado) @(posedge ck);
        #1;

        @(negedge ck);
        X = 16'd256; COEF = c3; inicio = 1'b1;
        @(posedge ck); #1 inicio = 1'b0;
        repeat (3) @(posedge ck);
        #2 rst = 1'b0;
        #1;
        chk("arst_res", Resultado, 0);
        chk("arst_pronto", pronto, 0);
        chk("arst_ov", overflow, 0);
        chk("arst_ocupado", ocupado, 0);
        @(negedge ck); rst = 1'b1;
        run("c2_after_rst", 16'hFFFD, c2, 16'd4, 1'b0);

        repeat (400) begin
            @(negedge ck);
            inicio = ($urandom_range(3) == 0);
            if ($urandom_range(1) == 0) begin
                X = 16'($signed($urandom_range(8)) - 4);
                COEF = pack($urandom_range(8) - 4, $urandom_range(8) - 4,
                            $urandom_range(8) - 4, $urandom_range(8) - 4);
            end else begin
                X = 16'($urandom);
                COEF = {$urandom, $urandom};
            end
        end
        @(negedge ck); inicio = 1'b0;
        repeat (10) @(negedge ck);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
